// File: rtl/nco_reset_sequencer_pkg.sv
// Shared types and constants for the NCO reset sequencer: state encoding,
// counter widths and default parameter values.
package nco_reset_sequencer_pkg;

    localparam int HOLD_CNT_W         = 8;
    localparam int TMO_CNT_W          = 20;

    localparam int DEF_NUM_TILES      = 4;
    localparam int DEF_HOLD_CYCLES    = 8;
    localparam int DEF_TIMEOUT_CYCLES = 65535;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_SYSREF = 2'd1,
        ST_ASSERT      = 2'd2,
        ST_WAIT_ACK    = 2'd3
    } nco_state_e;

endpackage

// File: rtl/nco_reset_sequencer_if.sv
// Control/status bundle between the RFDC timing block and the NCO reset
// sequencer; master drives the requests, slave is the sequencer.
interface nco_reset_sequencer_if
    import nco_reset_sequencer_pkg::*;
#(
    parameter int NUM_TILES = DEF_NUM_TILES
);

    logic                 start_nco_reset;
    logic                 sysref_pulse;
    logic [NUM_TILES-1:0] tile_ack;
    logic [NUM_TILES-1:0] nco_reset_req;
    logic                 nco_reset_done;
    logic                 nco_reset_busy;
    logic                 timeout_err;

    modport master (
        output start_nco_reset,
        output sysref_pulse,
        output tile_ack,
        input  nco_reset_req,
        input  nco_reset_done,
        input  nco_reset_busy,
        input  timeout_err
    );

    modport slave (
        input  start_nco_reset,
        input  sysref_pulse,
        input  tile_ack,
        output nco_reset_req,
        output nco_reset_done,
        output nco_reset_busy,
        output timeout_err
    );

endinterface

// File: rtl/nco_reset_sequencer.sv
// Sequences a SYSREF-aligned NCO reset across all RFDC tiles and waits for
// every tile to acknowledge, with a timeout on each wait.
//
// state          | meaning
// ST_IDLE        | waiting for start_nco_reset
// ST_WAIT_SYSREF | armed, waiting for the next sysref_pulse (timed)
// ST_ASSERT      | nco_reset_req high for HOLD_CYCLES cycles
// ST_WAIT_ACK    | waiting for all tile_ack bits (timed)
module nco_reset_sequencer
    import nco_reset_sequencer_pkg::*;
#(
    parameter int NUM_TILES      = DEF_NUM_TILES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    nco_reset_sequencer_if.slave  bus
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [TMO_CNT_W-1:0]  TMO_LOAD  = TMO_CNT_W'(TIMEOUT_CYCLES);

    nco_state_e            state_q, state_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [TMO_CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  all_ack;

    assign all_ack = &bus.tile_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        done_d     = done_q;
        err_d      = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_nco_reset) begin
                    state_d   = ST_WAIT_SYSREF;
                    tmo_cnt_d = TMO_LOAD;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                end
            end
            ST_WAIT_SYSREF: begin
                if (bus.sysref_pulse) begin
                    state_d    = ST_ASSERT;
                    hold_cnt_d = HOLD_LOAD;
                end else if (tmo_cnt_q == '0) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
            end
            ST_ASSERT: begin
                if (hold_cnt_q == '0) begin
                    state_d   = ST_WAIT_ACK;
                    tmo_cnt_d = TMO_LOAD;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                // Acks are checked before expiry so a last-cycle ack still completes.
                if (all_ack) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (tmo_cnt_q == '0) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request decodes the state register only, so reset clears it without a clock.
    always_comb begin
        bus.nco_reset_req  = {NUM_TILES{state_q == ST_ASSERT}};
        bus.nco_reset_busy = (state_q != ST_IDLE);
        bus.nco_reset_done = done_q;
        bus.timeout_err    = err_q;
    end

endmodule

// File: tb/tb_nco_reset_sequencer.sv
// Scoreboard bench for nco_reset_sequencer: stimulus queues expected output
// edges with their cycle numbers, a negedge monitor pops and compares them.
module tb_nco_reset_sequencer;

    localparam int NT   = 4;
    localparam int HOLD = 8;
    localparam int TMO  = 100;

    typedef enum int {
        EV_REQ_RISE, EV_REQ_FALL, EV_DONE_RISE, EV_DONE_FALL,
        EV_ERR_RISE, EV_ERR_FALL, EV_BUSY_RISE, EV_BUSY_FALL
    } ev_e;

    typedef struct {
        ev_e kind;
        int  cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   t;
    ev_t  exp_q[$];

    nco_reset_sequencer_if #(.NUM_TILES(NT)) bus ();

    nco_reset_sequencer #(
        .NUM_TILES      (NT),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_ev(input ev_e k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_e k);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL event: got %s at cycle %0d, expected no event", k.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                n_bad++;
                $display("FAIL event: got %s at cycle %0d, expected %s at cycle %0d",
                         k.name(), cyc, e.kind.name(), e.cyc);
            end
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: output edges seen at the falling clock edge of cycle cyc.
    logic req_p = 1'b0, done_p = 1'b0, err_p = 1'b0, busy_p = 1'b0;
    always @(negedge clk) begin
        logic req_n;
        req_n = |bus.nco_reset_req;
        if (req_n && !req_p) begin
            observe(EV_REQ_RISE);
            check("req_all_ones", 32'(bus.nco_reset_req), 32'hF);
        end
        if (!req_n && req_p)                        observe(EV_REQ_FALL);
        if (bus.nco_reset_done && !done_p)          observe(EV_DONE_RISE);
        if (!bus.nco_reset_done && done_p)          observe(EV_DONE_FALL);
        if (bus.timeout_err && !err_p)              observe(EV_ERR_RISE);
        if (!bus.timeout_err && err_p)              observe(EV_ERR_FALL);
        if (bus.nco_reset_busy && !busy_p)          observe(EV_BUSY_RISE);
        if (!bus.nco_reset_busy && busy_p)          observe(EV_BUSY_FALL);
        req_p  = req_n;
        done_p = bus.nco_reset_done;
        err_p  = bus.timeout_err;
        busy_p = bus.nco_reset_busy;
    end

    task automatic goto(input int c);
        if (cyc > c) begin
            n_cmp++;
            n_bad++;
            $display("FAIL schedule: at cycle %0d, expected to be at most %0d", cyc, c);
        end
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input int c);
        goto(c);
        bus.start_nco_reset = 1'b1;
        goto(c + 1);
        bus.start_nco_reset = 1'b0;
    endtask

    task automatic pulse_sysref(input int c);
        goto(c);
        bus.sysref_pulse = 1'b1;
        goto(c + 1);
        bus.sysref_pulse = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] req,
                                 input logic done, input logic busy, input logic err);
        check({tag, "_req"},  32'(bus.nco_reset_req),  32'(req));
        check({tag, "_done"}, 32'(bus.nco_reset_done), 32'(done));
        check({tag, "_busy"}, 32'(bus.nco_reset_busy), 32'(busy));
        check({tag, "_err"},  32'(bus.timeout_err),    32'(err));
    endtask

    initial begin
        bus.start_nco_reset = 1'b0;
        bus.sysref_pulse    = 1'b0;
        bus.tile_ack        = '0;
        #1 rst = 1'b1;
        goto(3);
        rst = 1'b0;
        goto(4);
        check_outputs("reset", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Nominal: start 10, sysref 20, acks 35.
        t = 10;
        expect_ev(EV_BUSY_RISE, t + 1);
        expect_ev(EV_REQ_RISE,  t + 11);
        expect_ev(EV_REQ_FALL,  t + 19);
        expect_ev(EV_DONE_RISE, t + 26);
        expect_ev(EV_BUSY_FALL, t + 26);
        pulse_start(t);
        pulse_sysref(t + 10);
        goto(t + 25);
        bus.tile_ack = 4'b1111;
        goto(t + 27);
        bus.tile_ack = 4'b0000;

        // Sysref coincident with start is ignored; the next one qualifies.
        t = cyc + 3;
        expect_ev(EV_DONE_FALL, t + 1);
        expect_ev(EV_BUSY_RISE, t + 1);
        expect_ev(EV_REQ_RISE,  t + 41);
        expect_ev(EV_REQ_FALL,  t + 49);
        expect_ev(EV_DONE_RISE, t + 53);
        expect_ev(EV_BUSY_FALL, t + 53);
        goto(t);
        bus.start_nco_reset = 1'b1;
        bus.sysref_pulse    = 1'b1;
        goto(t + 1);
        bus.start_nco_reset = 1'b0;
        bus.sysref_pulse    = 1'b0;
        pulse_sysref(t + 40);
        goto(t + 52);
        bus.tile_ack = 4'b1111;
        goto(t + 54);
        bus.tile_ack = 4'b0000;

        // No sysref: timeout after TMO+1 waiting cycles.
        t = cyc + 3;
        expect_ev(EV_DONE_FALL, t + 1);
        expect_ev(EV_BUSY_RISE, t + 1);
        expect_ev(EV_ERR_RISE,  t + 102);
        expect_ev(EV_BUSY_FALL, t + 102);
        pulse_start(t);
        goto(t + 104);
        check_outputs("sysref_tmo", 4'b0000, 1'b0, 1'b0, 1'b1);

        // Partial ack held past the ack timeout; start clears the old error.
        t = cyc + 2;
        expect_ev(EV_ERR_FALL,  t + 1);
        expect_ev(EV_BUSY_RISE, t + 1);
        expect_ev(EV_REQ_RISE,  t + 6);
        expect_ev(EV_REQ_FALL,  t + 14);
        expect_ev(EV_ERR_RISE,  t + 115);
        expect_ev(EV_BUSY_FALL, t + 115);
        pulse_start(t);
        bus.tile_ack = 4'b0111;
        pulse_sysref(t + 5);
        goto(t + 117);
        check_outputs("partial_ack", 4'b0000, 1'b0, 1'b0, 1'b1);
        bus.tile_ack = 4'b0000;

        // Acks already high before WAIT_ACK: done one cycle after entry.
        t = cyc + 2;
        expect_ev(EV_ERR_FALL,  t + 1);
        expect_ev(EV_BUSY_RISE, t + 1);
        expect_ev(EV_REQ_RISE,  t + 6);
        expect_ev(EV_REQ_FALL,  t + 14);
        expect_ev(EV_DONE_RISE, t + 15);
        expect_ev(EV_BUSY_FALL, t + 15);
        pulse_start(t);
        bus.tile_ack = 4'b1111;
        pulse_sysref(t + 5);
        goto(t + 16);
        bus.tile_ack = 4'b0000;

        // Second start during ASSERT is dropped.
        t = cyc + 2;
        expect_ev(EV_DONE_FALL, t + 1);
        expect_ev(EV_BUSY_RISE, t + 1);
        expect_ev(EV_REQ_RISE,  t + 4);
        expect_ev(EV_REQ_FALL,  t + 12);
        expect_ev(EV_DONE_RISE, t + 16);
        expect_ev(EV_BUSY_FALL, t + 16);
        pulse_start(t);
        pulse_sysref(t + 3);
        pulse_start(t + 6);
        goto(t + 15);
        bus.tile_ack = 4'b1111;
        goto(t + 17);
        bus.tile_ack = 4'b0000;
        goto(t + 30);

        // Reset on the third request cycle, then a full nominal run.
        t = cyc + 3;
        expect_ev(EV_DONE_FALL, t + 1);
        expect_ev(EV_BUSY_RISE, t + 1);
        expect_ev(EV_REQ_RISE,  t + 4);
        expect_ev(EV_REQ_FALL,  t + 6);
        expect_ev(EV_BUSY_FALL, t + 6);
        pulse_start(t);
        pulse_sysref(t + 3);
        goto(t + 6);
        rst = 1'b1;
        #1;
        check_outputs("async_rst", 4'b0000, 1'b0, 1'b0, 1'b0);
        goto(t + 8);
        rst = 1'b0;

        t = cyc + 3;
        expect_ev(EV_BUSY_RISE, t + 1);
        expect_ev(EV_REQ_RISE,  t + 11);
        expect_ev(EV_REQ_FALL,  t + 19);
        expect_ev(EV_DONE_RISE, t + 26);
        expect_ev(EV_BUSY_FALL, t + 26);
        pulse_start(t);
        pulse_sysref(t + 10);
        goto(t + 25);
        bus.tile_ack = 4'b1111;
        goto(t + 27);
        bus.tile_ack = 4'b0000;

        goto(cyc + 10);
        check("events_left", 32'(exp_q.size()), 32'd0);
        check_outputs("final", 4'b0000, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
